// File: rtl/da_accum.sv
// da_accum -- bit-serial distributed-arithmetic accumulator.
// Four input samples are consumed LSB first, one bit per clock. Each cycle the
// current bit of every sample forms a 4-bit ROM address (Addr3..Addr0). The ROM
// returns a partial sum R, which is accumulated with weight 2^k. The result y is
// held with out_valid until the consumer takes it with out_ready.
// Build option: define DA_SIGNED_EN to treat x0..x3 and R as two's complement.
// In that mode the MSB cycle subtracts its term; otherwise every cycle adds.
module da_accum #(
   parameter int XW = 16,
   parameter int RW = 28,
   parameter int YW = RW + XW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [XW-1:0] x0,
   input  logic [XW-1:0] x1,
   input  logic [XW-1:0] x2,
   input  logic [XW-1:0] x3,
   output logic          Addr0,
   output logic          Addr1,
   output logic          Addr2,
   output logic          Addr3,
   input  logic [RW-1:0] R,
   output logic [YW-1:0] y,
   output logic          out_valid,
   input  logic          out_ready
);

   localparam int KW = (XW > 1) ? $clog2(XW) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state_q;
   logic [XW-1:0]        x0_q, x1_q, x2_q, x3_q;
   logic [KW-1:0]        k_q;
   logic signed [YW-1:0] acc_q;
   logic signed [YW-1:0] acc_d;
   logic signed [YW-1:0] term;
   logic [YW-1:0]        y_q;
   logic                 in_ready_q;
   logic                 out_valid_q;
   logic                 last;

   // Widen the ROM word to the accumulator width (sign- or zero-extension).
   function automatic logic signed [YW-1:0] ext_r(input logic [RW-1:0] r);
`ifdef DA_SIGNED_EN
      ext_r = YW'($signed(r));
`else
      ext_r = $signed(YW'(r));
`endif
   endfunction

   assign last = (k_q == KW'(XW - 1));

   // Address bits follow the sample LSBs only while shifting; quiet otherwise.
   assign Addr0 = (state_q == SHIFT) & x0_q[0];
   assign Addr1 = (state_q == SHIFT) & x1_q[0];
   assign Addr2 = (state_q == SHIFT) & x2_q[0];
   assign Addr3 = (state_q == SHIFT) & x3_q[0];

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign y         = y_q;

   // Next accumulator value: add the weighted partial sum, or subtract it on the
   // sign-bit cycle when samples are two's complement. Wraps modulo 2^YW.
   always_comb begin
      term  = ext_r(R) << k_q;
      acc_d = acc_q + term;
`ifdef DA_SIGNED_EN
      if (last) begin
         acc_d = acc_q - term;
      end
`endif
   end

   // Control FSM with registered handshake outputs and the serial datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         k_q         <= '0;
         acc_q       <= '0;
         y_q         <= '0;
         x0_q        <= '0;
         x1_q        <= '0;
         x2_q        <= '0;
         x3_q        <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  x0_q       <= x0;
                  x1_q       <= x1;
                  x2_q       <= x2;
                  x3_q       <= x3;
                  acc_q      <= '0;
                  k_q        <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= SHIFT;
               end
            end
            SHIFT: begin
               acc_q <= acc_d;
               x0_q  <= x0_q >> 1;
               x1_q  <= x1_q >> 1;
               x2_q  <= x2_q >> 1;
               x3_q  <= x3_q >> 1;
               if (last) begin
                  // Final bit: publish the completed sum directly.
                  y_q         <= acc_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_da_accum.sv
// tb_da_accum -- self-checking bench for da_accum with a 4-tap coefficient ROM
// (Tw0=1, Tw1=2, Tw2=3, Tw3=4). Expected results come from a direct weighted
// sum of the samples. Honours DA_SIGNED_EN the same way as the design.
module tb_da_accum;

   localparam int XW = 16;
   localparam int RW = 28;
   localparam int YW = RW + XW;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [XW-1:0] x0, x1, x2, x3;
   logic          Addr0, Addr1, Addr2, Addr3;
   logic [RW-1:0] R;
   logic [YW-1:0] y;
   logic          out_valid;
   logic          out_ready;

   int checks   = 0;
   int failures = 0;

   logic [XW-1:0] ra, rb, rc, rd;
   logic [YW-1:0] exp_y;

   always #5 clk = ~clk;

   // Coefficient ROM: sum of the taps whose address bit is set.
   assign R = (Addr0 ? 28'd1 : 28'd0) + (Addr1 ? 28'd2 : 28'd0)
            + (Addr2 ? 28'd3 : 28'd0) + (Addr3 ? 28'd4 : 28'd0);

   da_accum #(.XW(XW), .RW(RW), .YW(YW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x0        (x0),
      .x1        (x1),
      .x2        (x2),
      .x3        (x3),
      .Addr0     (Addr0),
      .Addr1     (Addr1),
      .Addr2     (Addr2),
      .Addr3     (Addr3),
      .R         (R),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // Filter output as plain arithmetic: y = 1*x0 + 2*x1 + 3*x2 + 4*x3 mod 2^YW.
   function automatic logic [YW-1:0] model(input logic [XW-1:0] a, b, c, d);
      longint s;
`ifdef DA_SIGNED_EN
      s = longint'($signed(a)) + 2 * longint'($signed(b))
        + 3 * longint'($signed(c)) + 4 * longint'($signed(d));
`else
      s = longint'(a) + 2 * longint'(b) + 3 * longint'(c) + 4 * longint'(d);
`endif
      return s[YW-1:0];
   endfunction

   task automatic chk(input string tag, input logic [YW-1:0] obs, input logic [YW-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One complete operation from IDLE: accept, 16 shift cycles with address
   // checks, hold DONE for 'hold' cycles, then release. pulse_at >= 0 injects a
   // stray in_valid with junk data at that bit position.
   task automatic run_op(input logic [XW-1:0] a, b, c, d, input int hold, input int pulse_at);
      logic [YW-1:0] e;
      e = model(a, b, c, d);
      chk("idle_ready", YW'(in_ready), YW'(1'b1));
      x0 = a; x1 = b; x2 = c; x3 = d;
      in_valid = 1'b1;
      tick;                                   // accept edge
      in_valid = 1'b0;
      x0 = XW'($urandom); x1 = XW'($urandom); x2 = XW'($urandom); x3 = XW'($urandom);
      for (int k = 0; k < XW; k++) begin
         if (k == pulse_at) begin
            in_valid = 1'b1;
            x0 = XW'($urandom); x1 = XW'($urandom); x2 = XW'($urandom); x3 = XW'($urandom);
         end else begin
            in_valid = 1'b0;
         end
         chk("shift_addr", YW'({Addr3, Addr2, Addr1, Addr0}), YW'({d[k], c[k], b[k], a[k]}));
         chk("shift_ready", YW'(in_ready), YW'(1'b0));
         chk("shift_nvalid", YW'(out_valid), YW'(1'b0));
         tick;
      end
      in_valid = 1'b0;
      // 17th edge counting the accept edge: result must now be presented.
      chk("done_valid", YW'(out_valid), YW'(1'b1));
      chk("done_y", y, e);
      chk("done_addr", YW'({Addr3, Addr2, Addr1, Addr0}), YW'(4'd0));
      for (int i = 0; i < hold; i++) begin
         tick;
         chk("hold_valid", YW'(out_valid), YW'(1'b1));
         chk("hold_y", y, e);
         chk("hold_ready", YW'(in_ready), YW'(1'b0));
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk("rel_valid", YW'(out_valid), YW'(1'b0));
      chk("rel_ready", YW'(in_ready), YW'(1'b1));
      chk("rel_y_kept", y, e);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      x0 = '0; x1 = '0; x2 = '0; x3 = '0;

      // Reset state
      tick;
      tick;
      chk("rst_ready", YW'(in_ready), YW'(1'b1));
      chk("rst_valid", YW'(out_valid), YW'(1'b0));
      chk("rst_y", y, '0);
      chk("rst_addr", YW'({Addr3, Addr2, Addr1, Addr0}), YW'(4'd0));
      rst = 1'b0;
      tick;

      // All ones -> 10
      run_op(16'd1, 16'd1, 16'd1, 16'd1, 0, -1);
      chk("ones_y10", y, YW'(10));

      // 3,0,5,0 with out_ready low for 5 cycles -> 18
      run_op(16'd3, 16'd0, 16'd5, 16'd0, 5, -1);
      chk("mix_y18", y, YW'(18));

      // Sign handling of the MSB cycle
      run_op(16'hFFFF, 16'd0, 16'd0, 16'd0, 1, -1);
`ifdef DA_SIGNED_EN
      exp_y = {YW{1'b1}};
`else
      exp_y = YW'(65535);
`endif
      chk("msb_y", y, exp_y);

      // Stray in_valid during SHIFT is ignored
      run_op(16'h1234, 16'h0F0F, 16'h8001, 16'h7FFE, 2, 4);

      // Abort with reset at k=8, then a fresh operation
      x0 = 16'hBEEF; x1 = 16'hCAFE; x2 = 16'h1357; x3 = 16'h2468;
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      repeat (8) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("abort_ready", YW'(in_ready), YW'(1'b1));
      chk("abort_valid", YW'(out_valid), YW'(1'b0));
      chk("abort_y", y, '0);
      chk("abort_addr", YW'({Addr3, Addr2, Addr1, Addr0}), YW'(4'd0));
      run_op(16'd2, 16'd2, 16'd2, 16'd2, 0, -1);
      chk("fresh_y20", y, YW'(20));

      // Back-to-back with out_ready tied high and in_valid held high
      ra = 16'h00A5; rb = 16'h5A00; rc = 16'h0033; rd = 16'h4400;
      out_ready = 1'b1;
      x0 = ra; x1 = rb; x2 = rc; x3 = rd;
      in_valid = 1'b1;
      tick;                                   // first accept
      chk("b2b_busy1", YW'(in_ready), YW'(1'b0));
      x0 = 16'h0101; x1 = 16'h0202; x2 = 16'h0303; x3 = 16'h0404;
      repeat (16) tick;
      chk("b2b_valid1", YW'(out_valid), YW'(1'b1));
      chk("b2b_y1", y, model(ra, rb, rc, rd));
      tick;                                   // DONE exits
      chk("b2b_exit_valid", YW'(out_valid), YW'(1'b0));
      chk("b2b_exit_ready", YW'(in_ready), YW'(1'b1));
      tick;                                   // second accept
      chk("b2b_busy2", YW'(in_ready), YW'(1'b0));
      in_valid = 1'b0;
      repeat (16) tick;
      chk("b2b_valid2", YW'(out_valid), YW'(1'b1));
      chk("b2b_y2", y, model(16'h0101, 16'h0202, 16'h0303, 16'h0404));
      tick;
      chk("b2b_end_valid", YW'(out_valid), YW'(1'b0));
      out_ready = 1'b0;

      // Randomized operations against the weighted-sum model
      for (int i = 0; i < 8; i++) begin
         ra = XW'($urandom); rb = XW'($urandom); rc = XW'($urandom); rd = XW'($urandom);
         run_op(ra, rb, rc, rd, int'($urandom_range(0, 3)), -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
